// File: rtl/emif_frame_loader.sv
// -----------------------------------------------------------------------------
// emif_frame_loader
//   Collects 16-bit EMIF bus writes into a 320-bit shadow frame. A control
//   write commits the frame to reg0 and pulses reg1. reg2 is a sticky error
//   flag that is set by a commit of an incomplete frame. The bus strobes are
//   asynchronous to clk and are synchronized here before use.
//
// Ports
//   clk        system clock, posedge
//   rst        asynchronous reset, active-high
//   emif_cs_n  chip select, active-low, asynchronous
//   emif_we_n  write enable, active-low, asynchronous
//   emif_oe_n  output enable, active-low, asynchronous
//   emif_addr  word address
//   emif_din   write data
//   emif_dout  registered read data
//   reg0       committed frame, word i at bits [16i+15:16i]
//   reg1       one-clock commit strobe
//   reg2       sticky error flag
// -----------------------------------------------------------------------------
module emif_frame_loader #(
   parameter int unsigned        DATA_W    = 16,
   parameter int unsigned        ADDR_W    = 6,
   parameter int unsigned        NUM_WORDS = 20,
   parameter logic [ADDR_W-1:0]  CTRL_ADDR = ADDR_W'('h20),
   parameter logic [ADDR_W-1:0]  STAT_ADDR = ADDR_W'('h21)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          emif_cs_n,
   input  logic                          emif_we_n,
   input  logic                          emif_oe_n,
   input  logic [ADDR_W-1:0]             emif_addr,
   input  logic [DATA_W-1:0]             emif_din,
   output logic [DATA_W-1:0]             emif_dout,
   output logic [NUM_WORDS*DATA_W-1:0]   reg0,
   output logic                          reg1,
   output logic                          reg2
);

   localparam int unsigned       FRAME_W     = NUM_WORDS * DATA_W;
   localparam int unsigned       IDX_W       = $clog2(NUM_WORDS);
   localparam int unsigned       CNT_W       = $clog2(NUM_WORDS + 1);
   localparam logic [ADDR_W-1:0] NUM_WORDS_A = ADDR_W'(NUM_WORDS);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_FULL    = 2'd2,
      ST_COMMIT  = 2'd3
   } state_t;

   // Strobe synchronizers (reset to the idle level) and write-edge history
   logic [1:0]                        cs_sync_q;
   logic [1:0]                        we_sync_q;
   logic [1:0]                        oe_sync_q;
   logic                              we_prev_q;
   logic                              cs_s;
   logic                              we_s;
   logic                              oe_s;

   // Address/data held from the low phase of the synced write strobe
   logic [ADDR_W-1:0]                 addr_hold_q;
   logic [DATA_W-1:0]                 din_hold_q;

   // Frame state
   state_t                            state_q;
   logic [NUM_WORDS-1:0][DATA_W-1:0]  shadow_q;
   logic [NUM_WORDS-1:0]              mask_q;
   logic [FRAME_W-1:0]                reg0_q;
   logic                              reg1_q;
   logic                              reg2_q;
   logic [DATA_W-1:0]                 dout_q;

   // Decoded write/read controls
   logic                              wr_evt_c;
   logic                              data_wr_c;
   logic                              ctrl_wr_c;
   logic [IDX_W-1:0]                  wr_idx_c;
   logic [NUM_WORDS-1:0]              mask_set_c;
   logic                              mask_full_c;
   logic [CNT_W-1:0]                  mask_cnt_c;
   logic                              rd_en_c;
   logic [DATA_W-1:0]                 rd_data_c;

   function automatic logic [CNT_W-1:0] popcount(input logic [NUM_WORDS-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   assign cs_s = cs_sync_q[1];
   assign we_s = we_sync_q[1];
   assign oe_s = oe_sync_q[1];

   // Two-flop synchronizers on the bus strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync_q <= 2'b11;
         we_sync_q <= 2'b11;
         oe_sync_q <= 2'b11;
         we_prev_q <= 1'b1;
      end else begin
         cs_sync_q <= {cs_sync_q[0], emif_cs_n};
         we_sync_q <= {we_sync_q[0], emif_we_n};
         oe_sync_q <= {oe_sync_q[0], emif_oe_n};
         we_prev_q <= we_s;
      end
   end

   // Capture address/data while the synced strobe is low; the event uses the last capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_hold_q <= '0;
         din_hold_q  <= '0;
      end else if (!we_s) begin
         addr_hold_q <= emif_addr;
         din_hold_q  <= emif_din;
      end
   end

   // Write decode: rising edge of synced we_n with chip select active
   always_comb begin
      wr_evt_c    = we_s && !we_prev_q && !cs_s;
      data_wr_c   = wr_evt_c && (addr_hold_q < NUM_WORDS_A);
      ctrl_wr_c   = wr_evt_c && (addr_hold_q == CTRL_ADDR);
      wr_idx_c    = addr_hold_q[IDX_W-1:0];
      mask_set_c  = mask_q | (NUM_WORDS'(1) << wr_idx_c);
      mask_full_c = &mask_q;
      mask_cnt_c  = popcount(mask_q);
   end

   // Read mux: status word, shadow word, or zero
   always_comb begin
      rd_en_c   = !cs_s && !oe_s;
      rd_data_c = '0;
      if (emif_addr == STAT_ADDR) begin
         rd_data_c = DATA_W'({5'(mask_cnt_c), state_q, reg1_q, reg2_q, mask_full_c});
      end else if (emif_addr < NUM_WORDS_A) begin
         rd_data_c = shadow_q[emif_addr[IDX_W-1:0]];
      end
   end

   // Frame FSM with shadow, mask, committed frame and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         shadow_q <= '0;
         mask_q   <= '0;
         reg0_q   <= '0;
         reg1_q   <= 1'b0;
         reg2_q   <= 1'b0;
         dout_q   <= '0;
      end else begin
         reg1_q <= 1'b0;
         if (rd_en_c) begin
            dout_q <= rd_data_c;
         end
         case (state_q)
            // Commit lasts one clock; the shadow stays for readback
            ST_COMMIT: begin
               state_q <= ST_EMPTY;
               mask_q  <= '0;
            end
            default: begin
               if (data_wr_c) begin
                  shadow_q[wr_idx_c] <= din_hold_q;
                  mask_q             <= mask_set_c;
                  if (&mask_set_c) begin
                     state_q <= ST_FULL;
                  end else if (state_q == ST_EMPTY) begin
                     state_q <= ST_FILLING;
                  end
               end else if (ctrl_wr_c) begin
                  if (din_hold_q[2]) begin
                     shadow_q <= '0;
                     mask_q   <= '0;
                     state_q  <= ST_EMPTY;
                  end
                  if (din_hold_q[1]) begin
                     reg2_q <= 1'b0;
                  end
                  // Clear suppresses commit; a failed commit overrides error-clear
                  if (!din_hold_q[2] && din_hold_q[0]) begin
                     if (mask_full_c) begin
                        reg0_q  <= shadow_q;
                        reg1_q  <= 1'b1;
                        state_q <= ST_COMMIT;
                     end else begin
                        reg2_q <= 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign emif_dout = dout_q;
   assign reg0      = reg0_q;
   assign reg1      = reg1_q;
   assign reg2      = reg2_q;

endmodule

// File: tb/tb_emif_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_emif_frame_loader
//   Self-checking bench for emif_frame_loader. Drives asynchronous EMIF bus
//   cycles and compares outputs against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_emif_frame_loader;

   localparam logic [5:0] CTRL = 6'h20;
   localparam logic [5:0] STAT = 6'h21;

   logic          clk  = 1'b0;
   logic          rst  = 1'b1;
   logic          cs_n = 1'b1;
   logic          we_n = 1'b1;
   logic          oe_n = 1'b1;
   logic [5:0]    addr = '0;
   logic [15:0]   din  = '0;
   logic [15:0]   dout;
   logic [319:0]  reg0;
   logic          reg1;
   logic          reg2;

   int n_checks   = 0;
   int n_fail     = 0;
   int hi_cycles  = 0;
   int exp_pulses = 0;

   // Reference model state
   logic [15:0]   shadow_m [20];
   logic [19:0]   mask_m;
   logic [319:0]  reg0_m;
   logic          reg2_m;

   emif_frame_loader dut (
      .clk       (clk),
      .rst       (rst),
      .emif_cs_n (cs_n),
      .emif_we_n (we_n),
      .emif_oe_n (oe_n),
      .emif_addr (addr),
      .emif_din  (din),
      .emif_dout (dout),
      .reg0      (reg0),
      .reg1      (reg1),
      .reg2      (reg2)
   );

   always #5 clk = ~clk;

   // Total clocks with the commit strobe high
   always @(negedge clk) if (reg1 === 1'b1) hi_cycles++;

   function automatic void model_reset();
      for (int i = 0; i < 20; i++) shadow_m[i] = '0;
      mask_m = '0;
      reg0_m = '0;
      reg2_m = 1'b0;
   endfunction

   function automatic void model_write(input logic [5:0] a, input logic [15:0] d);
      if (a < 6'd20) begin
         shadow_m[a] = d;
         mask_m[a]   = 1'b1;
      end else if (a == CTRL) begin
         if (d[2]) begin
            for (int i = 0; i < 20; i++) shadow_m[i] = '0;
            mask_m = '0;
         end
         if (d[1]) reg2_m = 1'b0;
         if (!d[2] && d[0]) begin
            if (&mask_m) begin
               for (int i = 0; i < 20; i++) reg0_m[16*i +: 16] = shadow_m[i];
               mask_m = '0;
               exp_pulses++;
            end else begin
               reg2_m = 1'b1;
            end
         end
      end
   endfunction

   // Status word as seen between transactions (strobe already over)
   function automatic logic [15:0] stat_m();
      int cnt;
      logic [1:0] st;
      cnt = 0;
      for (int i = 0; i < 20; i++) cnt += int'(mask_m[i]);
      st = (cnt == 0) ? 2'd0 : (cnt == 20) ? 2'd2 : 2'd1;
      return {6'b0, 5'(cnt), st, 1'b0, reg2_m, (cnt == 20)};
   endfunction

   task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
      @(negedge clk);
      #($urandom_range(1, 4));
      addr = a;
      din  = d;
      cs_n = 1'b0;
      @(posedge clk); #2 we_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 we_n = 1'b1;
      repeat (3) @(posedge clk);
      #2 cs_n = 1'b1;
      repeat (2) @(posedge clk);
      model_write(a, d);
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [15:0] d);
      @(negedge clk);
      addr = a;
      cs_n = 1'b0;
      oe_n = 1'b0;
      repeat (4) @(posedge clk);
      #1 d = dout;
      @(negedge clk);
      cs_n = 1'b1;
      oe_n = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset();
      logic [15:0] rd;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (reg0 !== '0)     begin n_fail++; $display("FAIL reset_reg0: got %h want 0", reg0); end
      n_checks++; if (reg1 !== 1'b0)   begin n_fail++; $display("FAIL reset_reg1: got %b want 0", reg1); end
      n_checks++; if (reg2 !== 1'b0)   begin n_fail++; $display("FAIL reset_reg2: got %b want 0", reg2); end
      n_checks++; if (dout !== 16'h0)  begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      bus_read(STAT, rd);
      n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL reset_stat: got %h want 0000", rd); end
   endtask

   task automatic test_full_commit();
      logic [15:0] rd;
      int p0;
      for (int i = 0; i < 20; i++) bus_write(6'(i), 16'(i + 1));
      p0 = hi_cycles;
      bus_write(CTRL, 16'h0001);
      n_checks++; if (reg0 !== reg0_m) begin n_fail++; $display("FAIL commit_reg0: got %h want %h", reg0, reg0_m); end
      n_checks++; if (reg0[15:0] !== 16'd1) begin n_fail++; $display("FAIL commit_word0: got %h want 0001", reg0[15:0]); end
      n_checks++; if (reg0[319:304] !== 16'd20) begin n_fail++; $display("FAIL commit_word19: got %h want 0014", reg0[319:304]); end
      n_checks++; if (hi_cycles - p0 !== 1) begin n_fail++; $display("FAIL commit_pulse: got %0d high clocks want 1", hi_cycles - p0); end
      n_checks++; if (reg2 !== 1'b0) begin n_fail++; $display("FAIL commit_reg2: got %b want 0", reg2); end
      bus_read(STAT, rd);
      n_checks++; if (rd !== stat_m()) begin n_fail++; $display("FAIL commit_stat: got %h want %h", rd, stat_m()); end
   endtask

   task automatic test_partial_commit();
      logic [15:0] rd;
      int p0;
      for (int i = 0; i < 19; i++) bus_write(6'(i), 16'($urandom));
      p0 = hi_cycles;
      bus_write(CTRL, 16'h0001);
      n_checks++; if (reg2 !== 1'b1) begin n_fail++; $display("FAIL partial_reg2: got %b want 1", reg2); end
      n_checks++; if (reg0 !== reg0_m) begin n_fail++; $display("FAIL partial_reg0: got %h want %h", reg0, reg0_m); end
      n_checks++; if (hi_cycles - p0 !== 0) begin n_fail++; $display("FAIL partial_pulse: got %0d high clocks want 0", hi_cycles - p0); end
      bus_read(STAT, rd);
      n_checks++; if (rd !== stat_m()) begin n_fail++; $display("FAIL partial_stat: got %h want %h", rd, stat_m()); end
      bus_write(CTRL, 16'h0002);
      n_checks++; if (reg2 !== 1'b0) begin n_fail++; $display("FAIL partial_clr_err: got %b want 0", reg2); end
   endtask

   task automatic test_clear_commit();
      logic [15:0] rd;
      logic [319:0] r0;
      int p0;
      for (int i = 0; i < 20; i++) bus_write(6'(i), 16'($urandom) | 16'h1);
      r0 = reg0;
      p0 = hi_cycles;
      bus_write(CTRL, 16'h0005);
      n_checks++; if (hi_cycles - p0 !== 0) begin n_fail++; $display("FAIL clear_pulse: got %0d high clocks want 0", hi_cycles - p0); end
      n_checks++; if (reg2 !== 1'b0) begin n_fail++; $display("FAIL clear_reg2: got %b want 0", reg2); end
      n_checks++; if (reg0 !== reg0_m) begin n_fail++; $display("FAIL clear_reg0: got %h want %h", reg0, reg0_m); end
      bus_read(STAT, rd);
      n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL clear_stat: got %h want 0000", rd); end
      bus_read(6'd7, rd);
      n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL clear_shadow: got %h want 0000", rd); end
   endtask

   task automatic test_value();
      logic [15:0] rd;
      bus_write(6'd0, 16'h0064);
      for (int i = 1; i < 20; i++) bus_write(6'(i), 16'h0000);
      bus_write(CTRL, 16'h0001);
      n_checks++; if (reg0 !== 320'd100) begin n_fail++; $display("FAIL value_reg0: got %h want 100", reg0); end
      bus_write(6'd3, 16'h000A);
      bus_write(6'd3, 16'h000B);
      bus_read(6'd3, rd);
      n_checks++; if (rd !== 16'h000B) begin n_fail++; $display("FAIL rewrite_data: got %h want 000b", rd); end
      repeat (4) @(posedge clk);
      #1;
      n_checks++; if (dout !== 16'h000B) begin n_fail++; $display("FAIL dout_hold: got %h want 000b", dout); end
      bus_read(STAT, rd);
      n_checks++; if (rd !== stat_m()) begin n_fail++; $display("FAIL rewrite_stat: got %h want %h", rd, stat_m()); end
      n_checks++; if (rd[9:5] !== 5'd1) begin n_fail++; $display("FAIL rewrite_popcnt: got %0d want 1", rd[9:5]); end
      // Writes to unmapped addresses leave everything alone
      bus_write(6'h22, 16'hFFFF);
      bus_write(STAT, 16'hFFFF);
      bus_read(STAT, rd);
      n_checks++; if (rd !== stat_m()) begin n_fail++; $display("FAIL ignored_stat: got %h want %h", rd, stat_m()); end
   endtask

   task automatic test_random();
      logic [15:0] rd;
      int order [20];
      int j;
      int tmp;
      int idx;
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < 20; i++) order[i] = i;
         for (int i = 0; i < 19; i++) begin
            j = int'($urandom_range(i, 19));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
         end
         for (int i = 0; i < 20; i++) begin
            if ((r % 2 == 1) && i == 19) break;
            if ($urandom_range(0, 3) == 0)
               bus_write(($urandom_range(0, 1) != 0) ? 6'($urandom_range(20, 31))
                                                     : 6'($urandom_range(33, 63)), 16'($urandom));
            bus_write(6'(order[i]), 16'($urandom));
         end
         bus_write(CTRL, 16'($urandom_range(0, 7)));
         n_checks++; if (reg0 !== reg0_m) begin n_fail++; $display("FAIL rand_reg0 r%0d: got %h want %h", r, reg0, reg0_m); end
         n_checks++; if (reg2 !== reg2_m) begin n_fail++; $display("FAIL rand_reg2 r%0d: got %b want %b", r, reg2, reg2_m); end
         n_checks++; if (hi_cycles !== exp_pulses) begin n_fail++; $display("FAIL rand_pulses r%0d: got %0d want %0d", r, hi_cycles, exp_pulses); end
         bus_read(STAT, rd);
         n_checks++; if (rd !== stat_m()) begin n_fail++; $display("FAIL rand_stat r%0d: got %h want %h", r, rd, stat_m()); end
         idx = int'($urandom_range(0, 19));
         bus_read(6'(idx), rd);
         n_checks++; if (rd !== shadow_m[idx]) begin n_fail++; $display("FAIL rand_word r%0d w%0d: got %h want %h", r, idx, rd, shadow_m[idx]); end
      end
   endtask

   task automatic test_reset_midframe();
      logic [15:0] rd;
      bus_write(CTRL, 16'h0006);
      for (int i = 0; i < 10; i++) bus_write(6'(i), 16'($urandom) | 16'h8000);
      bus_read(6'd5, rd);
      n_checks++; if (rd !== shadow_m[5]) begin n_fail++; $display("FAIL mid_word5: got %h want %h", rd, shadow_m[5]); end
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      model_reset();
      n_checks++; if (reg0 !== '0)    begin n_fail++; $display("FAIL mid_rst_reg0: got %h want 0", reg0); end
      n_checks++; if (reg1 !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_reg1: got %b want 0", reg1); end
      n_checks++; if (reg2 !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_reg2: got %b want 0", reg2); end
      n_checks++; if (dout !== 16'h0) begin n_fail++; $display("FAIL mid_rst_dout: got %h want 0", dout); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      bus_read(STAT, rd);
      n_checks++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL mid_stat: got %h want 0000", rd); end
      bus_write(CTRL, 16'h0001);
      n_checks++; if (reg2 !== 1'b1) begin n_fail++; $display("FAIL mid_commit_err: got %b want 1", reg2); end
      n_checks++; if (reg0 !== '0) begin n_fail++; $display("FAIL mid_commit_reg0: got %h want 0", reg0); end
   endtask

   initial begin
      test_reset();
      test_full_commit();
      test_partial_commit();
      test_clear_commit();
      test_value();
      test_random();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
